// File: rtl/nes_bus_pkg.sv
// ============================================================================
// Module   : nes_bus_pkg
// Purpose  : Shared types and address-map constants for the NES CPU bus
//            responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nes_bus_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EXT_WAIT  = 3'd1,
        DMA_ALIGN = 3'd2,
        DMA_RD    = 3'd3,
        DMA_WR    = 3'd4
    } bus_state_t;

    localparam logic [15:0] RAM_END      = 16'h1FFF;
    localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
    localparam int          DMA_LEN      = 256;
    localparam logic [7:0]  OPEN_BUS     = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/nes_wram.sv
// ============================================================================
// Module   : nes_wram
// Purpose  : 2^AW x 8 synchronous single-port work RAM, 1-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nes_wram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    q
);

    logic [7:0] r_mem [0:(2**AW)-1];

    // Read port only updates on reads so q holds the last read byte.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= wdata;
            end else begin
                q <= r_mem[addr];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/nes_cpu_bus_responder.sv
// ============================================================================
// Module   : nes_cpu_bus_responder
// Purpose  : NES CPU bus slave: work RAM, external window handshake and
//            optional OAM DMA (enabled by macro NES_OAM_DMA_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nes_cpu_bus_responder
    import nes_bus_pkg::*;
#(
    parameter int RAM_AW      = 11,
    parameter int EXT_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_valid,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdy,
    output logic        ext_req,
    output logic [15:0] ext_addr,
    output logic        ext_we,
    output logic [7:0]  ext_wdata,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    output logic        oam_we,
    output logic [7:0]  oam_wdata
);

`ifdef NES_OAM_DMA_EN
    localparam logic c_DMA_EN = 1'b1;
`else
    localparam logic c_DMA_EN = 1'b0;
`endif
    localparam int c_TMO_W = (EXT_TIMEOUT > 1) ? $clog2(EXT_TIMEOUT) : 1;

    bus_state_t          r_state;
    bus_state_t          w_next;
    logic                r_rdy;
    logic                r_par;
    logic                r_sel_ram;
    logic [7:0]          r_rdata;
    logic [15:0]         r_ext_addr;
    logic                r_ext_we;
    logic [7:0]          r_ext_wdata;
    logic [7:0]          r_dma_page;
    logic [7:0]          r_dma_idx;
    logic [7:0]          r_dma_data;
    logic                r_dma_ram;
    logic [c_TMO_W-1:0]  r_tmo;
    logic [7:0]          w_ram_q;
    logic [15:0]         w_dma_addr;
    logic                w_accept;
    logic                w_is_ram;
    logic                w_is_dma;
    logic                w_is_ext;
    logic                w_tmo_hit;
    logic                w_ram_en;
    logic                w_ram_we;
    logic [RAM_AW-1:0]   w_ram_addr;

    assign w_dma_addr = {r_dma_page, r_dma_idx};
    assign w_accept   = (r_state == IDLE) && r_rdy && cpu_valid;
    assign w_is_ram   = (cpu_addr <= RAM_END);
    assign w_is_dma   = c_DMA_EN && (cpu_addr == OAM_DMA_ADDR);
    assign w_is_ext   = !w_is_ram && !w_is_dma;
    assign w_tmo_hit  = (r_tmo == c_TMO_W'(EXT_TIMEOUT - 1));

    assign w_ram_en   = (w_accept && w_is_ram) || ((r_state == DMA_RD) && r_dma_ram);
    assign w_ram_we   = w_accept && w_is_ram && !cpu_rw;
    assign w_ram_addr = (r_state == DMA_RD) ? w_dma_addr[RAM_AW-1:0] : cpu_addr[RAM_AW-1:0];

    nes_wram #(.AW(RAM_AW)) u_wram (
        .clk   (clk),
        .en    (w_ram_en),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (cpu_wdata),
        .q     (w_ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_ext) begin
                        w_next = EXT_WAIT;
                    end else if (w_is_dma && !cpu_rw) begin
                        w_next = r_par ? DMA_ALIGN : DMA_RD;
                    end
                end
            end
            EXT_WAIT:  if (ext_ack || w_tmo_hit) w_next = IDLE;
            DMA_ALIGN: w_next = DMA_RD;
            DMA_RD:    if (r_dma_ram || ext_ack || w_tmo_hit) w_next = DMA_WR;
            DMA_WR:    w_next = (r_dma_idx == 8'(DMA_LEN - 1)) ? IDLE : DMA_RD;
            default:   w_next = IDLE;
        endcase
    end

    // Datapath; cpu_rdy is only re-raised from IDLE, giving one resume cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy       <= 1'b1;
            r_par       <= 1'b0;
            r_sel_ram   <= 1'b0;
            r_rdata     <= 8'h00;
            r_ext_addr  <= 16'h0000;
            r_ext_we    <= 1'b0;
            r_ext_wdata <= 8'h00;
            r_dma_page  <= 8'h00;
            r_dma_idx   <= 8'h00;
            r_dma_data  <= 8'h00;
            r_dma_ram   <= 1'b0;
            r_tmo       <= '0;
        end else begin
            r_par <= ~r_par;
            case (r_state)
                IDLE: begin
                    if (!r_rdy) begin
                        r_rdy <= 1'b1;
                    end else if (cpu_valid) begin
                        if (w_is_ram) begin
                            if (cpu_rw) r_sel_ram <= 1'b1;
                        end else if (w_is_dma) begin
                            if (!cpu_rw) begin
                                r_rdy      <= 1'b0;
                                r_dma_page <= cpu_wdata;
                                r_dma_idx  <= 8'h00;
                                r_dma_ram  <= (cpu_wdata <= RAM_END[15:8]);
                                r_tmo      <= '0;
                            end else begin
                                r_sel_ram <= 1'b0;
                                r_rdata   <= OPEN_BUS;
                            end
                        end else begin
                            r_rdy       <= 1'b0;
                            r_ext_addr  <= cpu_addr;
                            r_ext_we    <= !cpu_rw;
                            r_ext_wdata <= cpu_wdata;
                            r_tmo       <= '0;
                        end
                    end
                end
                EXT_WAIT: begin
                    if (ext_ack || w_tmo_hit) begin
                        if (!r_ext_we) begin
                            r_sel_ram <= 1'b0;
                            r_rdata   <= ext_ack ? ext_rdata : OPEN_BUS;
                        end
                        r_tmo <= '0;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_W'(1);
                    end
                end
                DMA_RD: begin
                    if (!r_dma_ram) begin
                        if (ext_ack || w_tmo_hit) begin
                            r_dma_data <= ext_ack ? ext_rdata : OPEN_BUS;
                            r_tmo      <= '0;
                        end else begin
                            r_tmo <= r_tmo + c_TMO_W'(1);
                        end
                    end
                end
                DMA_WR:  r_dma_idx <= r_dma_idx + 8'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        cpu_rdy   = r_rdy;
        cpu_rdata = r_sel_ram ? w_ram_q : r_rdata;
        ext_req   = (r_state == EXT_WAIT) || ((r_state == DMA_RD) && !r_dma_ram);
        ext_addr  = (r_state == DMA_RD) ? w_dma_addr : r_ext_addr;
        ext_we    = (r_state == EXT_WAIT) && r_ext_we;
        ext_wdata = r_ext_wdata;
        oam_we    = c_DMA_EN && (r_state == DMA_WR);
        oam_wdata = 8'h00;
        if (oam_we) begin
            oam_wdata = r_dma_ram ? w_ram_q : r_dma_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nes_cpu_bus_responder.sv
// ============================================================================
// Module   : tb_nes_cpu_bus_responder
// Purpose  : Self-checking bench for nes_cpu_bus_responder (covers the
//            NES_OAM_DMA_EN build when that macro is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nes_cpu_bus_responder;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_valid = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_rw = 1'b1;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic        ext_req;
    logic [15:0] ext_addr;
    logic        ext_we;
    logic [7:0]  ext_wdata;
    logic        ext_ack = 1'b0;
    logic [7:0]  ext_rdata = 8'h00;
    logic        oam_we;
    logic [7:0]  oam_wdata;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  model_mem [0:2047];
    logic [7:0]  exp_oam [0:255];
    int          oam_cnt = 0;
    int          ack_delay = 0;
    int          req_cnt = 0;
    logic [7:0]  resp_data = 8'h00;
    logic [15:0] exp_ext_addr = 16'h0000;
    logic        exp_ext_we = 1'b0;
    logic [7:0]  exp_ext_wdata = 8'h00;
    logic        dma_mode = 1'b0;
    logic [7:0]  dma_page = 8'h00;
    logic        tb_par;

    nes_cpu_bus_responder #(.RAM_AW(11), .EXT_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_valid (cpu_valid),
        .cpu_addr  (cpu_addr),
        .cpu_rw    (cpu_rw),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_rdy   (cpu_rdy),
        .ext_req   (ext_req),
        .ext_addr  (ext_addr),
        .ext_we    (ext_we),
        .ext_wdata (ext_wdata),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata),
        .oam_we    (oam_we),
        .oam_wdata (oam_wdata)
    );

    always #5 clk = ~clk;

    // Cycle parity as seen by the design: cleared by reset, flips every edge.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_par <= 1'b0;
        else     tb_par <= ~tb_par;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ext_cycles(input int d);
        return (d >= 1 && d <= TMO) ? d : TMO;
    endfunction

    // External-side responder: acks on the ack_delay-th cycle of a request.
    always @(negedge clk) begin
        if (rst || !ext_req) begin
            req_cnt = 0;
            ext_ack = 1'b0;
        end else begin
            req_cnt++;
            if (ack_delay != 0 && req_cnt == ack_delay) begin
                ext_ack   = 1'b1;
                ext_rdata = dma_mode ? (ext_addr[7:0] ^ 8'hC3) : resp_data;
            end else begin
                ext_ack = 1'b0;
            end
        end
    end

    // Per-cycle compare of the external request and OAM stream.
    always @(negedge clk) begin
        if (!rst) begin
            if (ext_req) begin
                check("ext_addr", ext_addr, dma_mode ? {dma_page, 8'(oam_cnt)} : exp_ext_addr);
                check("ext_we", ext_we, dma_mode ? 1'b0 : exp_ext_we);
                if (!dma_mode && exp_ext_we) check("ext_wdata", ext_wdata, exp_ext_wdata);
            end
            if (oam_we) begin
                if (oam_cnt < 256) check("oam_data", oam_wdata, exp_oam[oam_cnt]);
                else               check("oam_extra", oam_cnt, 255);
                oam_cnt++;
            end
        end
    end

    task automatic cpu_access(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                              output int stall, output int reqc, output logic [7:0] rd);
        cpu_addr  = a;
        cpu_rw    = rw;
        cpu_wdata = wd;
        cpu_valid = 1'b1;
        stall = 0;
        reqc  = 0;
        @(negedge clk);
        while (!cpu_rdy && stall < 5000) begin
            if (ext_req) reqc++;
            stall++;
            @(negedge clk);
        end
        if (stall >= 5000) begin
            n_tests++;
            n_fail++;
            $display("FAIL rdy_bound: cpu_rdy stuck low, required high within 5000 cycles");
        end
        rd = cpu_rdata;
        cpu_valid = 1'b0;
    endtask

    task automatic ram_wr(input logic [15:0] a, input logic [7:0] d);
        int stall, reqc;
        logic [7:0] rd;
        cpu_access(a, 1'b0, d, stall, reqc, rd);
        check("ram_wr_stall", stall, 0);
        model_mem[a[10:0]] = d;
    endtask

    task automatic ram_rd(input logic [15:0] a, output logic [7:0] rd);
        int stall, reqc;
        cpu_access(a, 1'b1, 8'h00, stall, reqc, rd);
        check("ram_rd_stall", stall, 0);
        check("ram_rd_data", rd, model_mem[a[10:0]]);
    endtask

    task automatic do_ext(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                          input int d, input logic [7:0] resp,
                          output int stall, output int reqc, output logic [7:0] rd);
        exp_ext_addr  = a;
        exp_ext_we    = !rw;
        exp_ext_wdata = wd;
        ack_delay     = d;
        resp_data     = resp;
        cpu_access(a, rw, wd, stall, reqc, rd);
        check("ext_req_cycles", reqc, ext_cycles(d));
        check("ext_stall", stall, ext_cycles(d) + 1);
        if (rw) check("ext_rdata", rd, (d >= 1 && d <= TMO) ? resp : 8'hFF);
        ack_delay = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},   cpu_rdy, 1'b1);
        check({tag, "_rdata"}, cpu_rdata, 8'h00);
        check({tag, "_req"},   ext_req, 1'b0);
        check({tag, "_we"},    ext_we, 1'b0);
        check({tag, "_oam"},   oam_we, 1'b0);
    endtask

`ifdef NES_OAM_DMA_EN
    task automatic run_dma(input logic [7:0] page, input logic par, input int d);
        int stall, reqc, expst;
        logic [7:0] rd;
        logic [10:0] ma;
        while (tb_par != par) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            ma = {page[2:0], 8'(i)};
            exp_oam[i] = (page <= 8'h1F) ? model_mem[ma] : (8'(i) ^ 8'hC3);
        end
        dma_page  = page;
        dma_mode  = (page > 8'h1F);
        ack_delay = d;
        oam_cnt   = 0;
        cpu_access(16'h4014, 1'b0, page, stall, reqc, rd);
        expst = ((page <= 8'h1F) ? 512 : 256 * (ext_cycles(d) + 1)) + int'(par) + 1;
        check("dma_stall", stall, expst);
        check("dma_pulses", oam_cnt, 256);
        dma_mode  = 1'b0;
        ack_delay = 0;
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall, reqc;
        logic [7:0] rd;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_rel");

        for (int i = 0; i < 2048; i++) begin
            ram_wr(16'(i) | (16'($urandom_range(0, 3)) << 11), 8'($urandom));
        end

        // Mirror: write 0x0005, read back through 0x1805.
        ram_wr(16'h0005, 8'hA5);
        ram_rd(16'h1805, rd);
        check("lit_mirror", rd, 8'hA5);

        do_ext(16'h2002, 1'b1, 8'h00, 3, 8'h80, stall, reqc, rd);
        check("lit_ext_req3", reqc, 3);
        check("lit_ext_rdy4", stall, 4);
        check("lit_ext_data", rd, 8'h80);

        do_ext(16'h6000, 1'b1, 8'h00, 0, 8'h12, stall, reqc, rd);
        check("lit_tmo_req", reqc, 15);
        check("lit_tmo_data", rd, 8'hFF);
        @(negedge clk);
        check("lit_tmo_rdy", cpu_rdy, 1'b1);

        do_ext(16'h8123, 1'b0, 8'h3C, 1, 8'h00, stall, reqc, rd);
        do_ext(16'hC000, 1'b1, 8'h00, 15, 8'h5E, stall, reqc, rd);

        for (int k = 0; k < 200; k++) begin
            logic [15:0] a;
            case ($urandom_range(0, 3))
                0: ram_wr(16'($urandom_range(0, 16'h1FFF)), 8'($urandom));
                1: ram_rd(16'($urandom_range(0, 16'h1FFF)), rd);
                default: begin
                    a = 16'($urandom_range(16'h2000, 16'hFFFF));
                    if (a == 16'h4014) a = 16'h4015;
                    do_ext(a, 1'($urandom), 8'($urandom), $urandom_range(0, 17),
                           8'($urandom), stall, reqc, rd);
                end
            endcase
        end

        for (int i = 0; i < 256; i++) ram_wr(16'h0200 + 16'(i), 8'(i));

`ifdef NES_OAM_DMA_EN
        run_dma(8'h02, 1'b0, 0);
        run_dma(8'h02, 1'b1, 0);
        run_dma(8'h60, 1'b0, 2);

        // Reset in the middle of a DMA.
        while (tb_par != 1'b0) @(negedge clk);
        for (int i = 0; i < 256; i++) exp_oam[i] = 8'(i);
        dma_page  = 8'h02;
        oam_cnt   = 0;
        cpu_addr  = 16'h4014;
        cpu_rw    = 1'b0;
        cpu_wdata = 8'h02;
        cpu_valid = 1'b1;
        for (int n = 0; n < 1000 && oam_cnt < 100; n++) @(negedge clk);
        check("dma_reached_100", oam_cnt, 100);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_dma");
        @(negedge clk);
        cpu_valid = 1'b0;
        rst = 1'b0;
        ram_rd(16'h0264, rd);
        check("lit_post_rst", rd, 8'h64);
`else
        oam_cnt = 0;
        do_ext(16'h4014, 1'b0, 8'h02, 2, 8'h00, stall, reqc, rd);
        check("nodma_4014_req", reqc, 2);
        check("nodma_oam", oam_cnt, 0);
`endif

        // Reset while waiting on the external side.
        exp_ext_addr = 16'h3000;
        exp_ext_we   = 1'b0;
        ack_delay    = 0;
        cpu_addr     = 16'h3000;
        cpu_rw       = 1'b1;
        cpu_valid    = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_rst_req", ext_req, 1'b1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_ext");
        @(negedge clk);
        cpu_valid = 1'b0;
        rst = 1'b0;
        ram_rd(16'h0264, rd);
        ram_rd(16'h0005, rd);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
